// File: rtl/start_stop_conditioner.sv
// start_stop_conditioner
//   Front-end for the run/stop controller. Each raw button is passed through
//   a 2-flop synchroniser and a consecutive-sample debouncer. A registered
//   rising-edge detector then turns each debounced press into a one-cycle
//   command pulse. A hold-off window rate-limits start commands, and stop
//   always wins.
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous, active-high reset
//   start_btn_raw  in   raw start button (asynchronous to clk)
//   stop_btn_raw   in   raw stop button (asynchronous to clk)
//   start          out  one-cycle start command pulse
//   stop           out  one-cycle stop command pulse
//   start_level    out  debounced start button level
//   stop_level     out  debounced stop button level
//   busy           out  hold-off window active
module start_stop_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_btn_raw,
  input  logic stop_btn_raw,
  output logic start,
  output logic stop,
  output logic start_level,
  output logic stop_level,
  output logic busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  // Channel index 0 is start, index 1 is stop.
  logic [1:0]         raw;
  logic [1:0]         q1;
  logic [1:0]         q2;
  logic [1:0]         level;
  logic [1:0]         level_prev;
  logic [1:0]         rise;
  logic [1:0][CW-1:0] cnt;
  logic [HW-1:0]      hold;
  logic               start_ok;

  assign raw = {stop_btn_raw, start_btn_raw};

  // Two-flop synchronisers; only q2 feeds the logic below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= '0;
      q2 <= '0;
    end else begin
      q1 <= raw;
      q2 <= q1;
    end
  end

  // Debounce: level follows q2 only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= '0;
      level_prev <= '0;
      cnt        <= '0;
    end else begin
      level_prev <= level;
      for (int unsigned i = 0; i < 2; i++) begin
        if (q2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= ~level[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = level & ~level_prev;

  // busy reflects the hold-off counter of the current cycle, so a start
  // rise seen while busy is dropped rather than deferred.
  assign busy     = (hold != '0);
  assign start_ok = rise[0] & ~rise[1] & ~busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start <= 1'b0;
      stop  <= 1'b0;
      hold  <= '0;
    end else begin
      start <= start_ok;
      stop  <= rise[1];
      if (start_ok || rise[1]) begin
        hold <= HOLD_LOAD;
      end else if (hold != '0) begin
        hold <= hold - HOLD_ONE;
      end
    end
  end

  assign start_level = level[0];
  assign stop_level  = level[1];

endmodule
